fft_out_reorder: RTL and testbench
==================================

// Module: fft_out_reorder
// PURPOSE
//   Output-end consumer of the 32-point SDF FFT pipeline. The last butterfly stage emits bins in
//   bit-reversed order; this block captures each 32-sample frame in a ping-pong buffer and replays
//   it in natural order (bin 0..31) as a contiguous burst. It sits after the final stage and drives the top-level outputs.
// PARAMETERS
//   N     32  frame length (points); power of two
//   LOGN  5   log2(N); address/counter width
//   DW    16  signed sample width, real and imaginary parts each
// PORTS
//   clk         in   1     clock, all state updates on rising edge
//   rst_n       in   1     reset, asynchronous, active-low
//   valid_i     in   1     data_in_r/i carry one sample this cycle
//   data_in_r   in   DW    signed real part, bit-reversed frame order
//   data_in_i   in   DW    signed imaginary part
//   valid_o     out  1     data_out_r/i valid (registered)
//   sop_o       out  1     high with bin 0 of each output frame (registered)
//   data_out_r  out  DW    signed real part, natural order
//   data_out_i  out  DW    signed imaginary part
//   idx_o       out  LOGN  bin index of current output; present only with FFT_REORDER_IDX_EN
// BEHAVIOUR
//   Reset: valid_o=0, sop_o=0, data_out_r/i=0, idx_o=0; wr_cnt=0, wr_bank=0, full[1:0]=0, FSM=IDLE.
//     Reset mid-frame/mid-burst discards all buffered data; no partial frame is ever output.
//   Storage: two banks x N entries x 2*DW bits, register-based; no arithmetic, data passes unmodified.
//   Write side: each valid_i cycle writes bank[wr_bank][bitrev(wr_cnt)], wr_cnt++ (wraps at N-1->0).
//     valid_i may gap arbitrarily; wr_cnt holds while valid_i=0. On write with wr_cnt==N-1:
//     full[wr_bank]<=1, wr_bank toggles. Input sample j of a frame carries bin bitrev5(j).
//   Read FSM: IDLE, READ. rd_cnt LOGN bits, rd_bank 1 bit.
//     IDLE: if full[rd_bank] -> READ, rd_cnt=0.
//     READ: each cycle output bank[rd_bank][rd_cnt], valid_o=1, sop_o=(rd_cnt==0), rd_cnt++.
//       At rd_cnt==N-1: full[rd_bank]<=0, rd_bank toggles; if other bank already full (incl. set
//       same edge) stay in READ with rd_cnt=0 (no bubble), else -> IDLE.
//   Latency: bin 0 appears on valid_o exactly 1 cycle after the edge accepting input sample N-1
//     (IDLE case). Outputs are registered; valid_o=0 cycles drive data_out_r/i=0.
//   Burst: every output frame is N consecutive valid_o cycles regardless of input gaps.
//   Throughput: input <=1 sample/cycle guarantees a bank is freed (last read issued) no later than
//     the cycle its refill starts; writing a bank with full=1 is impossible by construction and is
//     flagged by a simulation-only assertion.
//   Simultaneous set of full[x] (write side) and clear of full[y] (read side) same edge: x!=y always; both apply.
// CONFIGURATION
//   FFT_REORDER_IDX_EN defined: idx_o port exists, registered, equals bin index of data_out_r/i
//     while valid_o=1, 0 otherwise. Undefined: port and its register absent; all else identical.
// TESTING
//   Reset: hold rst_n=0 with valid_i toggling -> all outputs 0, no valid_o after release until a full frame in.
//   Single frame: 32 contiguous inputs j with r=bitrev5(j), i=-bitrev5(j) -> 1 cycle after last input,
//     32 contiguous valid_o cycles with r=n, i=-n for n=0..31, sop_o only at n=0.
//   Back-to-back: 64 contiguous inputs (frame B = frame A + 100) -> 64 contiguous valid_o, sop_o at
//     outputs 0 and 32, frame B values n+100, no gap between frames.
//   Gapped input: valid_i every other cycle, one frame -> output identical to single-frame case,
//     burst still 32 contiguous cycles, starting 1 cycle after last accepted sample.
//   Mid-burst reset: assert rst_n=0 at output n=10 -> valid_o/data 0 asynchronously; next full frame
//     after release reorders correctly with sop_o at n=0.
//   FFT_REORDER_IDX_EN build: idx_o = 0..31 in step with data_out_r; 0 when valid_o=0; extreme values
//     r=32767/-32768, i=-32768/32767 pass unchanged.

Source files
------------

// File: rtl/fft_out_reorder_if.sv
// Sample stream bus around the FFT output reorder buffer: bit-reversed input side and natural-order output side.
// Pure wiring, no latency.
// No backpressure: input may gap freely, output bursts cannot stall. idx_o exists only with FFT_REORDER_IDX_EN.
interface fft_out_reorder_if #(
  parameter int DW   = 16,
  parameter int LOGN = 5
);
  logic                   valid_i;
  logic signed [DW-1:0]   data_in_r;
  logic signed [DW-1:0]   data_in_i;
  logic                   valid_o;
  logic                   sop_o;
  logic signed [DW-1:0]   data_out_r;
  logic signed [DW-1:0]   data_out_i;
`ifdef FFT_REORDER_IDX_EN
  logic [LOGN-1:0]        idx_o;
`endif

  // Upstream/downstream side: drives samples in, observes reordered samples out.
  modport master (
    output valid_i, data_in_r, data_in_i,
`ifdef FFT_REORDER_IDX_EN
    input  idx_o,
`endif
    input  valid_o, sop_o, data_out_r, data_out_i
  );

  // Reorder block side.
  modport slave (
    input  valid_i, data_in_r, data_in_i,
`ifdef FFT_REORDER_IDX_EN
    output idx_o,
`endif
    output valid_o, sop_o, data_out_r, data_out_i
  );
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong frame buffer turning bit-reversed FFT bins into natural-order bursts of N; optional idx_o via FFT_REORDER_IDX_EN.
// Latency: bin 0 is on valid_o one cycle after the edge that accepts input sample N-1 (when idle).
// No backpressure: input <=1 sample/cycle always finds a free bank; each output frame is N contiguous valid_o cycles.
module fft_out_reorder #(
  parameter int N    = 32,
  parameter int LOGN = 5,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  fft_out_reorder_if.slave bus
);

  typedef enum logic {IDLE, READ} state_t;

  state_t          state, state_nxt;
  logic [LOGN-1:0] wr_cnt;
  logic            wr_bank;
  logic [LOGN-1:0] rd_cnt, rd_cnt_nxt;
  logic            rd_bank, rd_bank_nxt;
  logic [1:0]      full, full_nxt, full_set, full_clr;
  logic            wr_last, issue, rd_last;

  logic [2*DW-1:0] mem [2][N];

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int k = 0; k < LOGN; k++) r[k] = a[LOGN-1-k];
    return r;
  endfunction

  assign wr_last  = bus.valid_i && (wr_cnt == LOGN'(N-1));
  assign full_set = wr_last ? (2'b01 << wr_bank) : 2'b00;
  assign full_clr = rd_last ? (2'b01 << rd_bank) : 2'b00;
  assign full_nxt = (full | full_set) & ~full_clr;

  // Sample storage: input sample j lands at its natural bin address bitrev(j); no reset needed since full[] gates reads.
  always_ff @(posedge clk) begin
    if (bus.valid_i) mem[wr_bank][bitrev(wr_cnt)] <= {bus.data_in_r, bus.data_in_i};
  end

  // Write pointer and bank-full flags; a completed frame hands its bank to the read side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      full <= full_nxt;
      if (bus.valid_i) begin
        wr_cnt <= wr_cnt + LOGN'(1);
        if (wr_last) wr_bank <= ~wr_bank;
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_cnt  <= rd_cnt_nxt;
      rd_bank <= rd_bank_nxt;
    end
  end

  // Read FSM next state: IDLE issues bin 0 the first cycle a bank is full so the burst starts without an extra bubble.
  always_comb begin
    state_nxt   = state;
    rd_cnt_nxt  = rd_cnt;
    rd_bank_nxt = rd_bank;
    issue       = 1'b0;
    rd_last     = 1'b0;
    case (state)
      IDLE:    issue = full[rd_bank];
      READ:    issue = 1'b1;
      default: issue = 1'b0;
    endcase
    if (issue) begin
      rd_cnt_nxt = rd_cnt + LOGN'(1);
      state_nxt  = READ;
      if (rd_cnt == LOGN'(N-1)) begin
        rd_last     = 1'b1;
        rd_bank_nxt = ~rd_bank;
        // Chain straight into the other bank if it is full now or fills on this same edge.
        if (!(full[~rd_bank] || full_set[~rd_bank])) state_nxt = IDLE;
      end
    end
  end

  // Registered outputs; data is forced to zero on non-valid cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_o    <= 1'b0;
      bus.sop_o      <= 1'b0;
      bus.data_out_r <= '0;
      bus.data_out_i <= '0;
    end else if (issue) begin
      bus.valid_o    <= 1'b1;
      bus.sop_o      <= (rd_cnt == '0);
      bus.data_out_r <= mem[rd_bank][rd_cnt][2*DW-1:DW];
      bus.data_out_i <= mem[rd_bank][rd_cnt][DW-1:0];
    end else begin
      bus.valid_o    <= 1'b0;
      bus.sop_o      <= 1'b0;
      bus.data_out_r <= '0;
      bus.data_out_i <= '0;
    end
  end

`ifdef FFT_REORDER_IDX_EN
  // Bin index tracks the data register: the read address when issuing, zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     bus.idx_o <= '0;
    else if (issue) bus.idx_o <= rd_cnt;
    else            bus.idx_o <= '0;
  end
`endif

`ifndef SYNTHESIS
  // A write into a bank still waiting to be replayed would corrupt an unread frame.
  a_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n) !(bus.valid_i && full[wr_bank]));
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: bit-reversed frames in, natural-order bursts checked against hand-derived values.
// Checks reset, single, back-to-back, gapped, extreme-value and mid-burst-reset cases.
// Input is driven without gaps except in the gapped case; output has no backpressure.
module tb_fft_out_reorder;
  localparam int N  = 32;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fft_out_reorder_if #(.DW(DW), .LOGN(5)) bus();

  fft_out_reorder #(.N(N), .LOGN(5), .DW(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  int q_r[$], q_i[$], q_sop[$], q_cyc[$], q_idx[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int brev5(input int j);
    logic [4:0] a;
    a = j[4:0];
    return int'({a[0], a[1], a[2], a[3], a[4]});
  endfunction

  // kind 0: r=n, i=-n; kind 1: r=n+100, i=-n+100; kind 2: alternating full-scale extremes.
  function automatic int val_r(input int kind, input int n);
    if (kind == 0) return n;
    if (kind == 1) return n + 100;
    return (n % 2 == 0) ? 32767 : -32768;
  endfunction

  function automatic int val_i(input int kind, input int n);
    if (kind == 0) return -n;
    if (kind == 1) return -n + 100;
    return (n % 2 == 0) ? -32768 : 32767;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: logs valid beats, and insists every non-valid cycle shows all-zero outputs.
  always @(negedge clk) begin
    if (bus.valid_o) begin
      q_r.push_back(int'(bus.data_out_r));
      q_i.push_back(int'(bus.data_out_i));
      q_sop.push_back(int'(bus.sop_o));
      q_cyc.push_back(cyc);
`ifdef FFT_REORDER_IDX_EN
      q_idx.push_back(int'(bus.idx_o));
`endif
    end else begin
`ifdef FFT_REORDER_IDX_EN
      chk("idle_zero", int'(bus.data_out_r != 0 || bus.data_out_i != 0 || bus.sop_o || bus.idx_o != 0), 0);
`else
      chk("idle_zero", int'(bus.data_out_r != 0 || bus.data_out_i != 0 || bus.sop_o), 0);
`endif
    end
  end

  task automatic clear_q();
    q_r.delete(); q_i.delete(); q_sop.delete(); q_cyc.delete(); q_idx.delete();
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  // Present one sample; returns #1 after its accepting edge with acc_cyc set to that edge.
  task automatic send(input int r, input int i);
    bus.valid_i   = 1'b1;
    bus.data_in_r = DW'(r);
    bus.data_in_i = DW'(i);
    @(posedge clk); #1;
    acc_cyc       = cyc;
    bus.valid_i   = 1'b0;
    bus.data_in_r = '0;
    bus.data_in_i = '0;
  endtask

  task automatic send_frame(input int kind, input int gap);
    for (int j = 0; j < N; j++) begin
      send(val_r(kind, brev5(j)), val_i(kind, brev5(j)));
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic check_frame(input string tag, input int off, input int kind, input int first);
    chk({tag, "_len"}, (q_r.size() >= off + N) ? 1 : 0, 1);
    if (q_r.size() >= off + N) begin
      for (int n = 0; n < N; n++) begin
        chk({tag, "_r"},   q_r[off+n],   val_r(kind, n));
        chk({tag, "_i"},   q_i[off+n],   val_i(kind, n));
        chk({tag, "_sop"}, q_sop[off+n], (n == 0) ? 1 : 0);
        chk({tag, "_cyc"}, q_cyc[off+n], first + n);
`ifdef FFT_REORDER_IDX_EN
        chk({tag, "_idx"}, q_idx[off+n], n);
`endif
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    bus.valid_i   = 1'b0;
    bus.data_in_r = '0;
    bus.data_in_i = '0;

    // Reset held with input activity: outputs must stay zero and nothing may emerge after release.
    #1 rst_n = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.valid_i   = k[0];
      bus.data_in_r = DW'(k + 7);
      bus.data_in_i = DW'(-k);
      @(negedge clk);
      chk("rst_valid", int'(bus.valid_o), 0);
      chk("rst_data",  int'(bus.data_out_r) | int'(bus.data_out_i), 0);
    end
    bus.valid_i = 1'b0;
    bus.data_in_r = '0;
    bus.data_in_i = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    clear_q();
    idle(40);
    chk("rst_no_out", q_r.size(), 0);

    // Single contiguous frame.
    clear_q();
    send_frame(0, 0);
    first = acc_cyc + 1;
    idle(40);
    chk("single_cnt", q_r.size(), N);
    check_frame("single", 0, 0, first);

    // Back-to-back frames: second frame must follow with no bubble.
    clear_q();
    send_frame(0, 0);
    first = acc_cyc + 1;
    send_frame(1, 0);
    idle(40);
    chk("b2b_cnt", q_r.size(), 2*N);
    check_frame("b2b_a", 0, 0, first);
    check_frame("b2b_b", N, 1, first + N);

    // Input every other cycle: output still one contiguous burst.
    clear_q();
    send_frame(0, 1);
    first = acc_cyc + 1;
    idle(40);
    chk("gap_cnt", q_r.size(), N);
    check_frame("gap", 0, 0, first);

    // Full-scale values must pass untouched.
    clear_q();
    send_frame(2, 0);
    first = acc_cyc + 1;
    idle(40);
    chk("ext_cnt", q_r.size(), N);
    check_frame("ext", 0, 2, first);

    // Reset while output bin 10 is being presented.
    clear_q();
    send_frame(0, 0);
    for (int k = 0; k < 60 && q_r.size() < 11; k++) begin
      @(negedge clk); #1;
    end
    chk("mid_reached", (q_r.size() >= 11) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", int'(bus.valid_o), 0);
    chk("mid_data_r", int'(bus.data_out_r), 0);
    chk("mid_data_i", int'(bus.data_out_i), 0);
    chk("mid_sop", int'(bus.sop_o), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_q();
    idle(40);
    chk("mid_no_out", q_r.size(), 0);
    send_frame(1, 0);
    first = acc_cyc + 1;
    idle(40);
    chk("post_cnt", q_r.size(), N);
    check_frame("post", 0, 1, first);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
